ahb_sram_if: RTL and testbench
==============================

// Module: ahb_sram_if
// PURPOSE
//  AHB-Lite slave front end that feeds the 8-bit single-port sram macros.
//  Converts AHB address/data-phase transfers into sram accesses on NUM_LANES byte lanes.
//  Each lane gets per-lane ce/we and a shared word address.
//  Zero-wait reads and writes; one wait state only on a write->read port conflict.
//  Two-cycle ERROR response for illegal size or misalignment.
// PARAMETERS
//  SRAM_ADDR_WIDTH  13  word address width of each lane macro (8192 words)
//  SRAM_DATA_WIDTH  8   lane width; bus width = NUM_LANES*SRAM_DATA_WIDTH
//  NUM_LANES        4   byte lanes; fixed 4 (32-bit AHB data)
// PORTS
//  clk          in   1    single clock; all logic on posedge
//  rst          in   1    reset, synchronous, active-high
//  hsel         in   1    slave select
//  haddr        in   32   byte address; word addr = haddr[SRAM_ADDR_WIDTH+1:2], upper bits alias
//  htrans       in   2    IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//  hwrite       in   1    1=write, 0=read
//  hsize        in   3    0=byte, 1=half, 2=word, >2 illegal
//  hready       in   1    bus HREADY (previous data phase complete)
//  hwdata       in   32   write data (data phase)
//  hrdata       out  32   read data
//  hready_resp  out  1    slave HREADYOUT
//  hresp        out  1    0=OKAY, 1=ERROR
//  sram_addr    out  13   word address to all lanes
//  sram_wdata   out  32   lane n gets [8n+7:8n]
//  sram_ce      out  4    per-lane chip enable
//  sram_we      out  4    per-lane write enable
//  sram_rdata   in   32   concatenated lane data_out, valid 1 cycle after a read ce
// BEHAVIOUR
//  Accept: hsel & htrans[1] & hready; IDLE/BUSY -> OKAY, zero wait, no sram access.
//  Lane mask (little endian): byte -> lane haddr[1:0]; half -> lanes {haddr[1],0}+{0,1};
//    word -> 4'hF.
//  Illegal: hsize>2, half with haddr[0]=1, word with haddr[1:0]!=0.
//  FSM (data-phase state): IDLE, WR, RD, RD_STALL, ERR1, ERR2; all states -> IDLE on rst.
//  Read accepted at T, port free: sram_ce=4'hF, sram_we=0, sram_addr=haddr word
//    (combinational, cycle T).
//    T+1 = RD: hrdata=sram_rdata, hready_resp=1.
//  Write accepted at T: addr and lane mask registered.
//    T+1 = WR: sram_ce=sram_we=mask, sram_addr=registered addr, sram_wdata=hwdata,
//    hready_resp=1.
//  Conflict: read accepted while in WR -> write owns port; read addr held in pending reg.
//    Next cycle = RD_STALL: hready_resp=0, sram_ce=4'hF, sram_we=0 at pending addr.
//    Following cycle = RD: data returned with hready_resp=1.
//  Write accepted while in WR: no conflict (its access falls in next cycle); back-to-back zero wait.
//  Illegal accepted at T: T+1 = ERR1: hresp=1, hready_resp=0.
//    T+2 = ERR2: hresp=1, hready_resp=1. No sram access.
//  hrdata = sram_rdata only in RD, else 0. Outside WR/RD_STALL/read issue: sram_ce=sram_we=0.
//  Reset values: hready_resp=1, hresp=0, hrdata=0, sram_ce=0, sram_we=0, sram_addr=0,
//    sram_wdata=0; pending read dropped.
//  rst mid-transfer: abandon without any write strobe; sram contents untouched.
//  Word address wraps: haddr 0x8000 aliases 0x0000.
// TESTING
//  Word write 0x0000_0010=0xDEADBEEF, then word read 0x10
//    -> we=4'hF at addr 4; read returns 0xDEADBEEF, no wait state.
//  Byte write 0xA5 to haddr 0x13 then word read 0x10
//    -> sram_we=4'b1000 only; read returns 0xA5ADBEEF.
//  Write 0x20 immediately followed by read 0x24 -> one cycle hready_resp=0 (RD_STALL);
//    read data correct; write strobe precedes read ce.
//  Half write at haddr 0x01, and hsize=3 -> ERR1/ERR2 two-cycle ERROR, sram_ce stays 0.
//  Assert rst during WR data phase -> next cycle all outputs at reset values;
//    later read of that address returns old data.
//  Back-to-back 8 NONSEQ writes then 8 reads, with htrans=BUSY inserted
//    -> zero waits except single write->read stall; all data matches.

Source files
------------

// File: rtl/ahb_sram_if.sv
// AHB-Lite slave front end for NUM_LANES x 8-bit single-port sram macros.
// Zero-wait reads/writes, one stall on write->read port conflict, two-cycle ERROR.
module ahb_sram_if #(
  parameter int unsigned SRAM_ADDR_WIDTH = 13,
  parameter int unsigned SRAM_DATA_WIDTH = 8,
  parameter int unsigned NUM_LANES       = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   hsel,
  input  logic [31:0]                            haddr,
  input  logic [1:0]                             htrans,
  input  logic                                   hwrite,
  input  logic [2:0]                             hsize,
  input  logic                                   hready,
  input  logic [NUM_LANES*SRAM_DATA_WIDTH-1:0]   hwdata,
  output logic [NUM_LANES*SRAM_DATA_WIDTH-1:0]   hrdata,
  output logic                                   hready_resp,
  output logic                                   hresp,
  output logic [SRAM_ADDR_WIDTH-1:0]             sram_addr,
  output logic [NUM_LANES*SRAM_DATA_WIDTH-1:0]   sram_wdata,
  output logic [NUM_LANES-1:0]                   sram_ce,
  output logic [NUM_LANES-1:0]                   sram_we,
  input  logic [NUM_LANES*SRAM_DATA_WIDTH-1:0]   sram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_STALL,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                     state_q, state_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_LANES-1:0]       mask_q, mask_d;

  logic                       accept;
  logic                       illegal;
  logic                       port_free;
  logic                       rd_issue;
  logic [NUM_LANES-1:0]       lane_mask;
  logic [SRAM_ADDR_WIDTH-1:0] word_addr;
  logic                       unused_bits;

  assign accept      = hsel & htrans[1] & hready;
  assign word_addr   = haddr[SRAM_ADDR_WIDTH+1:2];
  assign port_free   = (state_q == ST_IDLE) || (state_q == ST_RD) || (state_q == ST_ERR2);
  assign rd_issue    = accept & ~illegal & ~hwrite & port_free & ~rst;
  assign unused_bits = ^{haddr[31:SRAM_ADDR_WIDTH+2], htrans[0]};

  // Size/alignment decode into little-endian lane mask
  always_comb begin
    illegal   = 1'b0;
    lane_mask = '0;
    case (hsize)
      3'd0: lane_mask = NUM_LANES'(1) << haddr[1:0];
      3'd1: begin
        lane_mask = haddr[1] ? NUM_LANES'(4'b1100) : NUM_LANES'(4'b0011);
        illegal   = haddr[0];
      end
      3'd2: begin
        lane_mask = '1;
        illegal   = |haddr[1:0];
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

  // Next data-phase state and sram/bus outputs
  always_comb begin
    state_d     = ST_IDLE;
    addr_d      = addr_q;
    mask_d      = mask_q;
    hready_resp = 1'b1;
    hresp       = 1'b0;
    hrdata      = '0;
    sram_addr   = '0;
    sram_wdata  = '0;
    sram_ce     = '0;
    sram_we     = '0;

    case (state_q)
      ST_RD_STALL: state_d = ST_RD;
      ST_ERR1:     state_d = ST_ERR2;
      default: begin
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (hwrite) begin
            state_d = ST_WR;
            addr_d  = word_addr;
            mask_d  = lane_mask;
          end else if (state_q == ST_WR) begin
            // write owns the port this cycle; replay the read from addr_q next cycle
            state_d = ST_RD_STALL;
            addr_d  = word_addr;
          end else begin
            state_d = ST_RD;
          end
        end
      end
    endcase

    case (state_q)
      ST_WR: begin
        sram_ce    = mask_q;
        sram_we    = mask_q;
        sram_addr  = addr_q;
        sram_wdata = hwdata;
      end
      ST_RD: hrdata = sram_rdata;
      ST_RD_STALL: begin
        hready_resp = 1'b0;
        sram_ce     = '1;
        sram_addr   = addr_q;
      end
      ST_ERR1: begin
        hresp       = 1'b1;
        hready_resp = 1'b0;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase

    if (rd_issue) begin
      sram_ce   = '1;
      sram_we   = '0;
      sram_addr = word_addr;
    end

    // Abandon any in-flight access without a strobe while reset is held
    if (rst) begin
      hready_resp = 1'b1;
      hresp       = 1'b0;
      hrdata      = '0;
      sram_addr   = '0;
      sram_wdata  = '0;
      sram_ce     = '0;
      sram_we     = '0;
    end
  end

endmodule

// File: tb/tb_ahb_sram_if.sv
// Scoreboard bench for ahb_sram_if with a behavioural 4-lane sram and reference memory.
module tb_ahb_sram_if;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;

  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [12:0] addr;
    logic [1:0]  waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready_resp;
  logic        hresp;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_ce;
  logic [3:0]  sram_we;
  logic [31:0] sram_rdata;

  exp_t        exp_q[$];
  exp_t        cur;
  logic        dp_active = 1'b0;
  int          waits = 0;
  logic        prev_wr = 1'b0;
  logic [31:0] ref_mem [8192];
  logic [7:0]  mem [4][8192];
  logic [31:0] wdat [8];
  logic [31:0] old_word;
  int          n_checks = 0;
  int          n_pass = 0;

  assign hready = hready_resp;

  always #5 clk = ~clk;

  ahb_sram_if dut (
    .clk        (clk),
    .rst        (rst),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hready     (hready),
    .hwdata     (hwdata),
    .hrdata     (hrdata),
    .hready_resp(hready_resp),
    .hresp      (hresp),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_rdata (sram_rdata)
  );

  // Behavioural sram lanes: read data valid the cycle after ce
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (sram_ce[n]) begin
        if (sram_we[n]) mem[n][sram_addr] <= sram_wdata[8*n +: 8];
        else            sram_rdata[8*n +: 8] <= mem[n][sram_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Drive one address phase, push its expectation, wait for acceptance, then drive its data phase
  task automatic xfer(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd);
    exp_t        e;
    logic        bad;
    logic [3:0]  m;
    logic [12:0] idx;
    logic        rdy;
    int          guard;
    hsel   = 1'b1;
    htrans = tr;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
    idx    = a[14:2];
    bad    = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
    case (sz)
      3'd0:    m = 4'b0001 << a[1:0];
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    if (tr[1]) begin
      e.addr  = idx;
      e.mask  = m;
      e.waits = (bad || (!wr && prev_wr)) ? 2'd1 : 2'd0;
      if (bad) begin
        e.kind = K_ERR;
        e.data = 32'h0;
      end else if (wr) begin
        e.kind = K_WR;
        e.data = wd;
        for (int n = 0; n < 4; n++)
          if (m[n]) ref_mem[idx][8*n +: 8] = wd[8*n +: 8];
      end else begin
        e.kind = K_RD;
        e.data = ref_mem[idx];
      end
      exp_q.push_back(e);
    end
    prev_wr = tr[1] && wr && !bad;
    guard = 0;
    do begin
      @(negedge clk);
      rdy = hready_resp;
      @(posedge clk);
      guard++;
    end while (!rdy && guard < 20);
    check_eq("accept_timeout", 32'(rdy), 32'd1);
    #1;
    hwdata = (tr[1] && wr) ? wd : 32'h0;
  endtask

  task automatic idle();
    xfer(IDLE, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_hready_resp", 32'(hready_resp), 32'd1);
    check_eq("rst_hresp",       32'(hresp),       32'd0);
    check_eq("rst_hrdata",      hrdata,           32'd0);
    check_eq("rst_sram_ce",     32'(sram_ce),     32'd0);
    check_eq("rst_sram_we",     32'(sram_we),     32'd0);
    check_eq("rst_sram_addr",   32'(sram_addr),   32'd0);
    check_eq("rst_sram_wdata",  sram_wdata,       32'd0);
  endtask

  // Data-phase monitor: pops the scoreboard at acceptance, checks at completion
  initial forever begin
    @(negedge clk);
    if (rst) begin
      dp_active = 1'b0;
      waits     = 0;
      exp_q.delete();
    end else begin
      if (dp_active) begin
        if (cur.kind == K_ERR) begin
          check_eq("err_hresp", 32'(hresp),   32'd1);
          check_eq("err_ce",    32'(sram_ce), 32'd0);
        end
        if (hready_resp) begin
          check_eq("wait_states", 32'(waits), 32'(cur.waits));
          case (cur.kind)
            K_WR: begin
              check_eq("wr_we",     32'(sram_we),   32'(cur.mask));
              check_eq("wr_ce",     32'(sram_ce),   32'(cur.mask));
              check_eq("wr_addr",   32'(sram_addr), 32'(cur.addr));
              check_eq("wr_wdata",  sram_wdata,     cur.data);
              check_eq("wr_hrdata", hrdata,         32'd0);
              check_eq("wr_hresp",  32'(hresp),     32'd0);
            end
            K_RD: begin
              check_eq("rd_hrdata", hrdata,     cur.data);
              check_eq("rd_hresp",  32'(hresp), 32'd0);
            end
            default: ;
          endcase
          dp_active = 1'b0;
        end else begin
          waits++;
        end
      end
      if (hsel && htrans[1] && hready_resp) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
          dp_active = 1'b0;
        end else begin
          cur       = exp_q.pop_front();
          dp_active = 1'b1;
          waits     = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    hsel   = 1'b0;
    haddr  = 32'h0;
    htrans = IDLE;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;

    // Word write then read, byte lane merge, alias
    xfer(NONSEQ, 1'b1, 32'h0000_0010, 3'd2, 32'hDEADBEEF); idle();
    xfer(NONSEQ, 1'b0, 32'h0000_0010, 3'd2, 32'h0);        idle();
    xfer(NONSEQ, 1'b1, 32'h0000_0013, 3'd0, 32'hA500_0000); idle();
    xfer(NONSEQ, 1'b0, 32'h0000_0010, 3'd2, 32'h0);
    xfer(NONSEQ, 1'b0, 32'h0000_0013, 3'd0, 32'h0);
    xfer(NONSEQ, 1'b0, 32'h0000_8010, 3'd2, 32'h0);        idle();

    // Write->read conflicts, including same-address and half-word merge
    xfer(NONSEQ, 1'b1, 32'h0000_0024, 3'd2, 32'h12345678); idle();
    xfer(NONSEQ, 1'b1, 32'h0000_0020, 3'd2, 32'h0BADCAFE);
    xfer(NONSEQ, 1'b0, 32'h0000_0024, 3'd2, 32'h0);
    xfer(NONSEQ, 1'b0, 32'h0000_0020, 3'd2, 32'h0);        idle();
    xfer(NONSEQ, 1'b1, 32'h0000_0030, 3'd2, 32'h11223344); idle();
    xfer(NONSEQ, 1'b1, 32'h0000_0032, 3'd1, 32'hBEEF_0000);
    xfer(NONSEQ, 1'b0, 32'h0000_0030, 3'd2, 32'h0);        idle();

    // Illegal transfers
    xfer(NONSEQ, 1'b1, 32'h0000_0001, 3'd1, 32'h5555_5555);
    xfer(NONSEQ, 1'b0, 32'h0000_0000, 3'd3, 32'h0);
    xfer(NONSEQ, 1'b0, 32'h0000_0012, 3'd2, 32'h0);        idle();

    // Reset during a write data phase must not strobe the sram
    xfer(NONSEQ, 1'b1, 32'h0000_0040, 3'd2, 32'h0BADF00D); idle();
    old_word = ref_mem[16];
    xfer(NONSEQ, 1'b1, 32'h0000_0040, 3'd2, 32'hCAFEF00D);
    rst    = 1'b1;
    hsel   = 1'b0;
    htrans = IDLE;
    @(negedge clk);
    check_eq("rst_abort_we", 32'(sram_we), 32'd0);
    check_eq("rst_abort_ce", 32'(sram_ce), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    hwdata   = 32'h0;
    prev_wr  = 1'b0;
    ref_mem[16] = old_word;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    xfer(NONSEQ, 1'b0, 32'h0000_0040, 3'd2, 32'h0);        idle();

    // Burst of 8 writes then 8 reads with BUSY cycles inserted
    for (int i = 0; i < 8; i++) wdat[i] = $urandom;
    for (int i = 0; i < 8; i++) begin
      xfer((i == 0) ? NONSEQ : SEQ, 1'b1, 32'h100 + 32'(4*i), 3'd2, wdat[i]);
      if (i == 3) xfer(BUSY, 1'b1, 32'h100 + 32'(4*(i+1)), 3'd2, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      xfer((i == 0) ? NONSEQ : SEQ, 1'b0, 32'h100 + 32'(4*i), 3'd2, 32'h0);
      if (i == 5) xfer(BUSY, 1'b0, 32'h100 + 32'(4*(i+1)), 3'd2, 32'h0);
    end
    idle();
    idle();

    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
